// File: rtl/fp_pkg.sv
// Shared types for the fp multiplier arbiter: response payload and flag width.
package fp_pkg;

  localparam int unsigned FP_FLAGS_W = 4;
  localparam int unsigned FP_NUM_REQ = 4;
  localparam int unsigned FP_ID_W    = $clog2(FP_NUM_REQ);

  typedef logic [31:0] fp_32b_t;

  typedef struct packed {
    logic [FP_ID_W-1:0]    id;
    fp_32b_t               result;
    logic [FP_FLAGS_W-1:0] flags;
  } fp_mul_rsp_t;

endpackage

// File: rtl/fp_mul_rsp_fifo.sv
// Synchronous FIFO of multiplier responses; push while full and pop while empty are ignored.
module fp_mul_rsp_fifo
  import fp_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fp_mul_rsp_t   wdata,
  input  logic          pop,
  output fp_mul_rsp_t   rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  fp_mul_rsp_t   r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty  = (r_wr_ptr == r_rd_ptr);
  assign count  = CW'(r_wr_ptr - r_rd_ptr);
  assign rdata  = r_mem[r_rd_ptr[AW-1:0]];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: entries are only visible between push and pop.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin share of one fixed-latency multiplier between NUM_REQ requesters,
// with an ID tag pipe and a credit-protected response FIFO.
module fp_mul_arbiter
  import fp_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned MUL_LATENCY = 4,
  parameter int unsigned FIFO_DEPTH  = 8,
  localparam int unsigned ID_W       = $clog2(NUM_REQ),
  localparam int unsigned CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*32-1:0]   req_in1,
  input  logic [NUM_REQ*32-1:0]   req_in2,
  input  logic [NUM_REQ*3-1:0]    req_rm,
  output logic                    mul_valid_data_in,
  output logic [31:0]             mul_in1,
  output logic [31:0]             mul_in2,
  output logic [2:0]              mul_rounding_mode,
  input  logic                    mul_valid_data_out,
  input  logic [31:0]             mul_out,
  input  logic [FP_FLAGS_W-1:0]   mul_flags,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_result,
  output logic [FP_FLAGS_W-1:0]   rsp_flags,
  output logic                    busy,
  output logic                    seq_error
);

  logic [31:0]      w_in1 [NUM_REQ];
  logic [31:0]      w_in2 [NUM_REQ];
  logic [2:0]       w_rm  [NUM_REQ];

  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_issue_id;
  logic [CW-1:0]    r_credits;
  logic [MUL_LATENCY-1:0] r_tag_vld;
  logic [ID_W-1:0]  r_tag_id [MUL_LATENCY];

  logic             w_grant_vld;
  logic [ID_W-1:0]  w_grant_id;
  logic [ID_W-1:0]  w_idx;
  logic             w_credit_ok;
  logic             w_accept;
  logic             w_pop;
  logic             w_pop_cred;
  logic             w_tail_vld;
  logic [ID_W-1:0]  w_tail_id;

  fp_mul_rsp_t      w_wdata;
  fp_mul_rsp_t      w_rdata;
  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_count;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign w_in1[g] = req_in1[g*32 +: 32];
    assign w_in2[g] = req_in2[g*32 +: 32];
    assign w_rm[g]  = req_rm[g*3 +: 3];
  end

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    w_idx       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = ID_W'((32'(r_ptr) + k) % NUM_REQ);
      if (!w_grant_vld && req_valid[w_idx]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = w_idx;
      end
    end
  end

  assign w_credit_ok = (r_credits < CW'(FIFO_DEPTH));
  assign w_accept    = w_grant_vld & w_credit_ok & ~rst;
  assign req_ready   = w_accept ? (NUM_REQ'(1) << w_grant_id) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_valid_data_in <= 1'b0;
      mul_in1           <= '0;
      mul_in2           <= '0;
      mul_rounding_mode <= '0;
      r_issue_id        <= '0;
      r_ptr             <= '0;
    end else begin
      mul_valid_data_in <= w_accept;
      if (w_accept) begin
        mul_in1           <= w_in1[w_grant_id];
        mul_in2           <= w_in2[w_grant_id];
        mul_rounding_mode <= w_rm[w_grant_id];
        r_issue_id        <= w_grant_id;
        r_ptr             <= (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + ID_W'(1);
      end
    end
  end

  // Tag pipe follows the registered issue so its tail lines up with the multiplier output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_vld <= '0;
      for (int unsigned i = 0; i < MUL_LATENCY; i++) r_tag_id[i] <= '0;
    end else begin
      r_tag_vld   <= {r_tag_vld[MUL_LATENCY-2:0], mul_valid_data_in};
      r_tag_id[0] <= r_issue_id;
      for (int unsigned i = 1; i < MUL_LATENCY; i++) r_tag_id[i] <= r_tag_id[i-1];
    end
  end

  assign w_tail_vld = r_tag_vld[MUL_LATENCY-1];
  assign w_tail_id  = r_tag_id[MUL_LATENCY-1];

  always_ff @(posedge clk) begin
    if (rst)                                  seq_error <= 1'b0;
    else if (mul_valid_data_out != w_tail_vld) seq_error <= 1'b1;
  end

  assign w_wdata = '{id: FP_ID_W'(w_tail_id), result: mul_out, flags: mul_flags};

  fp_mul_rsp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (mul_valid_data_out),
    .wdata (w_wdata),
    .pop   (w_pop),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign rsp_valid  = ~w_empty;
  assign w_pop      = rsp_valid & rsp_ready;
  assign rsp_id     = rsp_valid ? ID_W'(w_rdata.id) : '0;
  assign rsp_result = rsp_valid ? w_rdata.result  : '0;
  assign rsp_flags  = rsp_valid ? w_rdata.flags   : '0;

  // A spurious result carries no credit, so never let the counter wrap below zero.
  assign w_pop_cred = w_pop & (r_credits != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_credits <= '0;
    end else begin
      unique case ({w_accept, w_pop_cred})
        2'b10:   r_credits <= r_credits + CW'(1);
        2'b01:   r_credits <= r_credits - CW'(1);
        default: r_credits <= r_credits;
      endcase
    end
  end

  assign busy = (r_credits != '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(mul_valid_data_out && w_full));
  a_credit_cover: assert property (@(posedge clk) disable iff (rst || seq_error)
                                   32'(w_count) <= 32'(r_credits));

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: multiplier stub, transaction-level model checked every cycle, directed tests.
module tb_fp_mul_arbiter;
  import fp_pkg::*;

  localparam int N = 4;
  localparam int L = 4;
  localparam int D = 8;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_in1;
  logic [N*32-1:0] req_in2;
  logic [N*3-1:0]  req_rm;
  logic            mul_valid_data_in;
  logic [31:0]     mul_in1;
  logic [31:0]     mul_in2;
  logic [2:0]      mul_rounding_mode;
  logic            mul_valid_data_out;
  logic [31:0]     mul_out;
  logic [3:0]      mul_flags;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [31:0]     rsp_result;
  logic [3:0]      rsp_flags;
  logic            busy;
  logic            seq_error;
  logic            inj;

  int checks = 0;
  int errors = 0;

  fp_mul_arbiter #(.NUM_REQ(N), .MUL_LATENCY(L), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .req_rm(req_rm),
    .mul_valid_data_in(mul_valid_data_in), .mul_in1(mul_in1), .mul_in2(mul_in2),
    .mul_rounding_mode(mul_rounding_mode),
    .mul_valid_data_out(mul_valid_data_out), .mul_out(mul_out), .mul_flags(mul_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .busy(busy), .seq_error(seq_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Truncating product of two normal singles; exact for the operands used here.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] m;
    int          e;
    logic [22:0] f;
    m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (m[47]) begin f = m[46:24]; e = e + 1; end
    else       f = m[45:23];
    return {a[31] ^ b[31], 8'(e), f};
  endfunction

  function automatic logic [3:0] fflags(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] m;
    m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    return {3'b000, m[47] ? (m[23:0] != 0) : (m[22:0] != 0)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Multiplier stub: L-cycle pipe, cleared by the shared reset.
  logic [L-1:0] s_v;
  logic [31:0]  s_d [L];
  logic [3:0]   s_f [L];
  always @(posedge clk) begin
    if (rst) begin
      s_v <= '0;
    end else begin
      s_v    <= {s_v[L-2:0], mul_valid_data_in};
      s_d[0] <= fmul(mul_in1, mul_in2);
      s_f[0] <= fflags(mul_in1, mul_in2);
      for (int i = 1; i < L; i++) begin
        s_d[i] <= s_d[i-1];
        s_f[i] <= s_f[i-1];
      end
    end
  end
  assign mul_valid_data_out = s_v[L-1] | inj;
  assign mul_out            = s_d[L-1];
  assign mul_flags          = s_f[L-1];

  // Transaction model: expected responses in issue order with their earliest visible cycle.
  typedef struct {
    int          id;
    logic [31:0] res;
    logic [3:0]  fl;
    int          t;
    bit          spur;
  } exp_t;

  exp_t        q[$];
  int          acc_log[$];
  int          pop_log[$];
  int          m_ptr = 0;
  int          m_cred = 0;
  int          cyc = 0;
  bit          m_lacc = 0;
  bit          m_seq = 0;
  bit          armed = 0;
  logic [31:0] m_in1 = '0;
  logic [31:0] m_in2 = '0;
  logic [2:0]  m_rm = '0;
  logic [N-1:0] n_er;
  int          n_gid;
  bit          n_erv;
  bit          n_pop;

  always @(negedge clk) begin
    n_er  = '0;
    n_gid = -1;
    if (!rst && m_cred < D)
      for (int k = 0; k < N; k++)
        if (n_gid < 0 && req_valid[(m_ptr + k) % N]) n_gid = (m_ptr + k) % N;
    if (n_gid >= 0) n_er[n_gid] = 1'b1;
    n_erv = (q.size() > 0) && (q[0].t <= cyc);
    if (armed) begin
      chk("req_ready", 32'(req_ready), 32'(n_er));
      chk("mul_valid", 32'(mul_valid_data_in), 32'(m_lacc));
      chk("mul_in1", mul_in1, m_in1);
      chk("mul_in2", mul_in2, m_in2);
      chk("mul_rm", 32'(mul_rounding_mode), 32'(m_rm));
      chk("rsp_valid", 32'(rsp_valid), 32'(n_erv));
      chk("busy", 32'(busy), 32'(m_cred != 0));
      chk("seq_error", 32'(seq_error), 32'(m_seq));
      if (n_erv && !q[0].spur) begin
        chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
        chk("rsp_result", rsp_result, q[0].res);
        chk("rsp_flags", 32'(rsp_flags), 32'(q[0].fl));
      end
    end
    n_pop = n_erv && rsp_ready;
    if (rst) begin
      q.delete();
      m_ptr = 0; m_cred = 0; m_lacc = 0; m_seq = 0;
      m_in1 = '0; m_in2 = '0; m_rm = '0;
      armed = 1;
    end else begin
      if (n_pop) begin
        if (!q[0].spur) begin
          m_cred--;
          pop_log.push_back(q[0].id);
        end
        void'(q.pop_front());
      end
      if (inj) begin
        m_seq = 1;
        q.push_back('{0, 32'h0, 4'h0, cyc + 1, 1'b1});
      end
      if (n_gid >= 0) begin
        m_in1 = req_in1[n_gid*32 +: 32];
        m_in2 = req_in2[n_gid*32 +: 32];
        m_rm  = req_rm[n_gid*3 +: 3];
        q.push_back('{n_gid, fmul(m_in1, m_in2), fflags(m_in1, m_in2), cyc + 2 + L, 1'b0});
        m_cred++;
        m_ptr  = (n_gid + 1) % N;
        m_lacc = 1;
        acc_log.push_back(n_gid);
      end else begin
        m_lacc = 0;
      end
    end
    cyc++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  int base;
  int n;

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; inj = 1'b0;
    req_rm = '0;
    for (int i = 0; i < N; i++) begin
      req_in1[i*32 +: 32] = 32'h3F800000 | (32'(i) << 20);
      req_in2[i*32 +: 32] = 32'h40000000 | (32'(i) << 19);
      req_rm[i*3 +: 3]    = 3'(i + 1);
    end
    chk("pin_1x2", fmul(32'h3F800000, 32'h40000000), 32'h40000000);
    chk("pin_3x2", fmul(32'h40400000, 32'h40000000), 32'h40C00000);
    chk("pin_flags", 32'(fflags(32'h3F800000, 32'h40000000)), 32'h0);
    tick(2);
    rst = 1'b0;

    // Idle after reset.
    tick(10);
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("idle_mul_valid", 32'(mul_valid_data_in), 32'h0);

    // Single operation from requester 0: 1.0 * 2.0.
    rsp_ready = 1'b1;
    req_in1[31:0] = 32'h3F800000;
    req_in2[31:0] = 32'h40000000;
    req_valid = 4'b0001;
    #1;
    chk("single_ready", 32'(req_ready), 32'h1);
    tick(1);
    req_valid = '0;
    chk("single_mul_valid", 32'(mul_valid_data_in), 32'h1);
    chk("single_mul_in1", mul_in1, 32'h3F800000);
    n = 1;
    while (!rsp_valid && n < 20) begin
      tick(1);
      n++;
    end
    chk("single_latency", 32'(n), 32'(2 + L));
    chk("single_rsp_id", 32'(rsp_id), 32'h0);
    chk("single_rsp_result", rsp_result, 32'h40000000);
    tick(10);

    // All requesters for 8 cycles: grant order and response order.
    rst_pulse();
    base = acc_log.size();
    n = pop_log.size();
    req_valid = 4'b1111;
    tick(8);
    req_valid = '0;
    tick(16);
    chk("rr_accepts", 32'(acc_log.size() - base), 32'h8);
    chk("rr_rsps", 32'(pop_log.size() - n), 32'h8);
    for (int i = 0; i < 8; i++) begin
      if (acc_log.size() > base + i) chk("rr_grant_order", 32'(acc_log[base + i]), 32'(i % 4));
      if (pop_log.size() > n + i)    chk("rr_rsp_order", 32'(pop_log[n + i]), 32'(i % 4));
    end

    // Backpressure: credits cap outstanding work at D.
    rst_pulse();
    rsp_ready = 1'b0;
    base = acc_log.size();
    req_valid = 4'b1111;
    tick(14);
    chk("bp_accepts", 32'(acc_log.size() - base), 32'(D));
    chk("bp_ready_zero", 32'(req_ready), 32'h0);
    chk("bp_busy", 32'(busy), 32'h1);
    rsp_ready = 1'b1;
    #1;
    chk("bp_ready_on_pop", 32'(req_ready), 32'h0);
    tick(1);
    chk("bp_ready_after_pop", 32'(req_ready != 0), 32'h1);
    tick(12);
    req_valid = '0;
    tick(20);
    chk("bp_drained", 32'(busy), 32'h0);

    // Spurious multiplier valid.
    rst_pulse();
    tick(2);
    inj = 1'b1;
    tick(1);
    inj = 1'b0;
    chk("seq_set", 32'(seq_error), 32'h1);
    tick(5);
    chk("seq_sticky", 32'(seq_error), 32'h1);
    rst_pulse();
    chk("seq_cleared", 32'(seq_error), 32'h0);

    // Reset with operations in flight.
    tick(2);
    base = acc_log.size();
    req_valid = 4'b1111;
    tick(3);
    req_valid = '0;
    chk("flight_accepts", 32'(acc_log.size() - base), 32'h3);
    tick(1);
    rst_pulse();
    chk("flight_busy", 32'(busy), 32'h0);
    chk("flight_rsp_valid", 32'(rsp_valid), 32'h0);
    n = pop_log.size();
    req_valid = 4'b1111;
    #1;
    chk("flight_ptr0", 32'(req_ready), 32'h1);
    tick(1);
    req_valid = '0;
    tick(20);
    chk("flight_rsp_count", 32'(pop_log.size() - n), 32'h1);
    if (pop_log.size() > n) chk("flight_rsp_id", 32'(pop_log[n]), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
